// File: rtl/bram_dm_pkg.sv
// -----------------------------------------------------------------------------
// bram_dm_pkg
// Shared types and constants for the AXI-Stream <-> BRAM datamover.
//   dm_state_t   : control FSM states
//   ERR_*        : bit positions inside the 3-bit status error field
//   DIR_*        : encoding of the command direction bit (cmd_write)
// -----------------------------------------------------------------------------
package bram_dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } dm_state_t;

    localparam int ERR_W       = 3;
    localparam int ERR_ZERO    = 0;
    localparam int ERR_EARLY   = 1;
    localparam int ERR_MISSING = 2;

    localparam logic DIR_S2MM = 1'b1;
    localparam logic DIR_MM2S = 1'b0;

endpackage : bram_dm_pkg

// File: rtl/bram_dm_skid.sv
// -----------------------------------------------------------------------------
// bram_dm_skid
// Two-entry fall-through FIFO between the BRAM read port and the MM2S stream.
// Each entry carries a data word plus its tlast flag. When empty, an incoming
// word is presented on the output in the same cycle it arrives, so the BRAM
// read latency is the only latency on the read path. The occupancy count is
// exported so the read issuer never has more words outstanding than fit.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset (flushes FIFO)
//   push_valid        : a BRAM read word is arriving this cycle
//   push_data/last    : the arriving word and its end-of-transfer flag
//   out_valid/ready   : AXI-Stream style output handshake
//   out_data/last     : head-of-FIFO word (or the arriving word when empty)
//   count             : registered number of stored entries (0..2)
// -----------------------------------------------------------------------------
module bram_dm_skid
    import bram_dm_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        count
);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q,  count_d;

    logic   stored;
    logic   pop;
    entry_t head;

    assign head   = mem_q[rd_ptr_q];
    assign stored = (count_q != 2'd0);

    // Fall-through output: the arriving word bypasses storage when empty.
    assign out_valid = stored || push_valid;
    assign out_data  = stored ? head.data : push_data;
    assign out_last  = stored ? head.last : push_last;
    assign count     = count_q;
    assign pop       = out_valid && out_ready;

    // Every arriving word is written and every handshake advances the read
    // pointer, so the bypass case (push and pop while empty) leaves the
    // pointers aligned and the count unchanged without special handling.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_valid) begin
            mem_d[wr_ptr_q] = '{last: push_last, data: push_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push_valid) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; it is never observed while count_q is 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : bram_dm_skid

// File: rtl/axis_bram_datamover.sv
// -----------------------------------------------------------------------------
// axis_bram_datamover
// Command-driven mover between AXI-Stream and a single-port BRAM (latency 1).
// A command moves cmd_len beats starting at cmd_addr, wrapping at the BRAM
// depth, either stream->BRAM (S2MM, cmd_write=1) or BRAM->stream (MM2S,
// cmd_write=0). One single-cycle status pulse reports tag, beats moved and
// error flags {missing_last, early_last, zero_len} per command.
//
// Ports
//   clk_in1, reset            : clock, synchronous active-high reset
//   cmd_*                     : command handshake, direction, addr, len, tag
//   s_axis_*                  : S2MM input stream (ready only while writing)
//   m_axis_*                  : MM2S output stream, fed through a 2-entry skid
//   bram_*                    : BRAM port; rdata valid one cycle after a read
//   sts_*                     : status pulse and fields, no backpressure
// -----------------------------------------------------------------------------
module axis_bram_datamover
    import bram_dm_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16,
    parameter int TAG_W  = 4
) (
    input  logic              clk_in1,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [TAG_W-1:0]  cmd_tag,

    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,

    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,

    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,

    output logic              sts_valid,
    output logic [TAG_W-1:0]  sts_tag,
    output logic [LEN_W-1:0]  sts_beats,
    output logic [ERR_W-1:0]  sts_err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    // ------------------------------------------------------------------ state
    dm_state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q,     addr_d;      // next BRAM word to touch
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [TAG_W-1:0]  tag_q,      tag_d;
    logic [LEN_W-1:0]  beats_q,    beats_d;     // beats completed on the stream
    logic [LEN_W-1:0]  issued_q,   issued_d;    // MM2S reads issued to BRAM
    logic [ERR_W-1:0]  err_q,      err_d;
    logic              rd_pend_q,  rd_pend_d;   // a read word arrives this cycle
    logic              rd_last_q,  rd_last_d;   // ... and it is the final beat
    logic              rst_done_q, rst_done_d;  // holds cmd_ready low in reset

    // ------------------------------------------------------------ skid FIFO
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_last;
    logic [1:0]        skid_count;

    bram_dm_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk_in1),
        .reset      (reset),
        .push_valid (rd_pend_q),
        .push_data  (bram_rdata),
        .push_last  (rd_last_q),
        .out_valid  (skid_valid),
        .out_data   (skid_data),
        .out_last   (skid_last),
        .out_ready  (m_axis_tready),
        .count      (skid_count)
    );

    // ------------------------------------------------------- shared strobes
    logic accept;
    logic wr_fire;
    logic wr_final;
    logic rd_room;
    logic rd_issue;
    logic m_fire;

    assign accept   = cmd_valid && cmd_ready;
    assign wr_fire  = (state_q == ST_WRITE) && s_axis_tvalid;
    assign wr_final = (beats_q == (len_q - LEN_ONE));
    // Stored words plus the word in flight must stay below the FIFO depth,
    // so a returning read always has a slot even under full backpressure.
    assign rd_room  = ({1'b0, skid_count} + {2'b00, rd_pend_q}) < 3'd2;
    assign rd_issue = (state_q == ST_READ) && (issued_q < len_q) && rd_room;
    assign m_fire   = skid_valid && m_axis_tready;

    // -------------------------------------------------- FSM: state register
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------- FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        state_d = ST_DONE;
                    end else if (cmd_write == DIR_S2MM) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_fire && (wr_final || s_axis_tlast)) begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (m_fire && skid_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------- FSM: output logic
    always_comb begin
        cmd_ready     = (state_q == ST_IDLE) && rst_done_q;
        s_axis_tready = (state_q == ST_WRITE);
        bram_en       = wr_fire || rd_issue;
        bram_we       = wr_fire;
        bram_addr     = addr_q;
        bram_wdata    = wr_fire ? s_axis_tdata : '0;
        m_axis_tvalid = skid_valid;
        m_axis_tdata  = skid_valid ? skid_data : '0;
        m_axis_tlast  = skid_valid && skid_last;
        sts_valid     = (state_q == ST_DONE);
        sts_tag       = tag_q;
        sts_beats     = beats_q;
        sts_err       = err_q;
    end

    // ------------------------------------------------------- datapath next
    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        tag_d      = tag_q;
        beats_d    = beats_q;
        issued_d   = issued_q;
        err_d      = err_q;
        rd_pend_d  = rd_issue;
        rd_last_d  = rd_issue && (issued_q == (len_q - LEN_ONE));
        rst_done_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d          = cmd_addr;
                    len_d           = cmd_len;
                    tag_d           = cmd_tag;
                    beats_d         = '0;
                    issued_d        = '0;
                    err_d           = '0;
                    err_d[ERR_ZERO] = (cmd_len == '0);
                end
            end
            ST_WRITE: begin
                if (wr_fire) begin
                    addr_d  = addr_q + ADDR_ONE;
                    beats_d = beats_q + LEN_ONE;
                    if (wr_final) begin
                        err_d[ERR_MISSING] = !s_axis_tlast;
                    end else if (s_axis_tlast) begin
                        err_d[ERR_EARLY] = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (rd_issue) begin
                    addr_d   = addr_q + ADDR_ONE;
                    issued_d = issued_q + LEN_ONE;
                end
                if (m_fire) begin
                    beats_d = beats_q + LEN_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------- datapath registers
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            addr_q     <= '0;
            len_q      <= '0;
            tag_q      <= '0;
            beats_q    <= '0;
            issued_q   <= '0;
            err_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            len_q      <= len_d;
            tag_q      <= tag_d;
            beats_q    <= beats_d;
            issued_q   <= issued_d;
            err_q      <= err_d;
            rd_pend_q  <= rd_pend_d;
            rd_last_q  <= rd_last_d;
            rst_done_q <= rst_done_d;
        end
    end

endmodule : axis_bram_datamover

// File: tb/tb_axis_bram_datamover.sv
// -----------------------------------------------------------------------------
// tb_axis_bram_datamover
// Self-checking bench for axis_bram_datamover. A behavioural BRAM answers the
// DUT's memory port; a reference array holds the words each S2MM command is
// expected to leave in memory, computed from address/length/tlast rules.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_bram_datamover;
    import bram_dm_pkg::*;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 16;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk_in1 = 1'b0;
    logic              reset   = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr  = '0;
    logic [LEN_W-1:0]  cmd_len   = '0;
    logic [TAG_W-1:0]  cmd_tag   = '0;
    logic [DATA_W-1:0] s_axis_tdata  = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tlast  = 1'b0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic              sts_valid;
    logic [TAG_W-1:0]  sts_tag;
    logic [LEN_W-1:0]  sts_beats;
    logic [ERR_W-1:0]  sts_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] bram_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem  [DEPTH];

    always #5 clk_in1 = ~clk_in1;

    axis_bram_datamover #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk_in1       (clk_in1),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_tag       (cmd_tag),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata),
        .sts_valid     (sts_valid),
        .sts_tag       (sts_tag),
        .sts_beats     (sts_beats),
        .sts_err       (sts_err)
    );

    // Single-port BRAM, read latency 1, read data held until the next read.
    always @(posedge clk_in1) begin
        if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_wdata;
            else         bram_rdata <= bram_mem[bram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] addr,
                             input int len, input logic [TAG_W-1:0] tag);
        @(posedge clk_in1); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        cmd_tag   = tag;
        @(negedge clk_in1);
        check("cmd_ready_at_accept", cmd_ready, 1);
        @(posedge clk_in1); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [TAG_W-1:0] tag,
                                input int beats, input logic [2:0] err);
        @(negedge clk_in1);
        check({name, "_sts_valid"}, sts_valid, 1);
        check({name, "_sts_tag"},   sts_tag, tag);
        check({name, "_sts_beats"}, sts_beats, beats);
        check({name, "_sts_err"},   sts_err, err);
        @(posedge clk_in1); #1;
        @(negedge clk_in1);
        check({name, "_sts_one_cycle"}, sts_valid, 0);
        check({name, "_cmd_ready_back"}, cmd_ready, 1);
    endtask

    // S2MM: beat i carries base+i; tlast is raised on beat last_pos (-1: never).
    task automatic do_s2mm(input logic [ADDR_W-1:0] addr, input int len, input logic [TAG_W-1:0] tag,
                           input int last_pos, input bit rnd_valid, input logic [DATA_W-1:0] base);
        int exp_beats;
        logic [2:0] exp_err;
        int i;
        int cyc;
        bit first;
        int widx;
        exp_beats = (last_pos >= 0 && last_pos < len) ? last_pos + 1 : len;
        exp_err   = '0;
        if (last_pos >= 0 && last_pos < len - 1) exp_err[ERR_EARLY] = 1'b1;
        else if (last_pos != len - 1)            exp_err[ERR_MISSING] = 1'b1;

        drive_cmd(DIR_S2MM, addr, len, tag);
        i = 0; cyc = 0; first = 1'b1;
        while (i < exp_beats && cyc < 2000) begin
            s_axis_tvalid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata  = base + DATA_W'(i);
            s_axis_tlast  = (i == last_pos);
            @(negedge clk_in1);
            if (first) begin
                check("s2mm_tready_after_accept", s_axis_tready, 1);
                first = 1'b0;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                widx = (int'(addr) + i) % DEPTH;
                check("s2mm_bram_en",    bram_en, 1);
                check("s2mm_bram_we",    bram_we, 1);
                check("s2mm_bram_addr",  bram_addr, widx);
                check("s2mm_bram_wdata", bram_wdata, s_axis_tdata);
                ref_mem[widx] = s_axis_tdata;
                i++;
            end else begin
                check("s2mm_idle_bram_en", bram_en, 0);
            end
            @(posedge clk_in1); #1;
            cyc++;
        end
        if (i < exp_beats) check("s2mm_timeout_beats", i, exp_beats);
        s_axis_tvalid = 1'b1;   // stray beat offered during status: must not be taken
        s_axis_tlast  = 1'b0;
        @(negedge clk_in1);
        check("s2mm_no_stray_accept", s_axis_tready, 0);
        check("s2mm_no_stray_write",  bram_en, 0);
        s_axis_tvalid = 1'b0;
        check("s2mm_sts_valid", sts_valid, 1);
        check("s2mm_sts_tag",   sts_tag, tag);
        check("s2mm_sts_beats", sts_beats, exp_beats);
        check("s2mm_sts_err",   sts_err, exp_err);
        @(posedge clk_in1); #1;
        @(negedge clk_in1);
        check("s2mm_sts_one_cycle", sts_valid, 0);
        check("s2mm_cmd_ready_back", cmd_ready, 1);
    endtask

    // MM2S ready modes: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic do_mm2s(input logic [ADDR_W-1:0] addr, input int len,
                           input logic [TAG_W-1:0] tag, input int mode);
        int k;
        int c;
        int first_en;
        int first_v;
        int last_c;
        bit prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic [3:0] pat;
        pat = 4'b1001;
        drive_cmd(DIR_MM2S, addr, len, tag);
        k = 0; c = 1; first_en = -1; first_v = -1; last_c = 0; prev_stall = 1'b0; prev_data = '0;
        while (k < len && c < 3000) begin
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = pat[3 - ((c - 1) % 4)];
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk_in1);
            if (bram_en && first_en < 0) first_en = c;
            if (m_axis_tvalid && first_v < 0) first_v = c;
            if (bram_en) check("mm2s_read_we_low", bram_we, 0);
            if (prev_stall) begin
                check("mm2s_hold_valid", m_axis_tvalid, 1);
                check("mm2s_hold_data",  m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("mm2s_tdata", m_axis_tdata, ref_mem[(int'(addr) + k) % DEPTH]);
                check("mm2s_tlast", m_axis_tlast, (k == len - 1));
                k++;
                last_c = c;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            @(posedge clk_in1); #1;
            c++;
        end
        if (k < len) check("mm2s_timeout_beats", k, len);
        check("mm2s_first_bram_en_cycle", first_en, 1);
        check("mm2s_first_tvalid_cycle",  first_v, 2);
        if (mode == 0) check("mm2s_full_rate_last_cycle", last_c, len + 1);
        m_axis_tready = 1'b1;
        @(negedge clk_in1);
        check("mm2s_no_extra_beat", m_axis_tvalid, 0);
        check("mm2s_sts_valid", sts_valid, 1);
        check("mm2s_sts_tag",   sts_tag, tag);
        check("mm2s_sts_beats", sts_beats, len);
        check("mm2s_sts_err",   sts_err, 0);
        @(posedge clk_in1); #1;
        @(negedge clk_in1);
        check("mm2s_sts_one_cycle", sts_valid, 0);
        check("mm2s_cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        logic [ADDR_W-1:0] r_addr;
        int r_len;
        int k;
        int c;

        // ---- reset state
        repeat (3) @(posedge clk_in1);
        @(negedge clk_in1);
        check("rst_cmd_ready",     cmd_ready, 0);
        check("rst_s_tready",      s_axis_tready, 0);
        check("rst_m_tvalid",      m_axis_tvalid, 0);
        check("rst_bram_en",       bram_en, 0);
        check("rst_sts_valid",     sts_valid, 0);
        check("rst_sts_fields",    {sts_tag, sts_beats, sts_err}, 0);
        @(posedge clk_in1); #1;
        reset = 1'b0;
        @(negedge clk_in1);
        check("rst_release_cycle_ready", cmd_ready, 0);
        @(posedge clk_in1); #1;
        @(negedge clk_in1);
        check("rst_cmd_ready_rises", cmd_ready, 1);

        // ---- directed S2MM then MM2S with 1,0,0,1 backpressure
        do_s2mm(12'h010, 8, 4'h1, 7, 1'b0, 64'd0);
        for (int i = 0; i < 8; i++) check("s2mm_bram_contents", bram_mem[16 + i], i);
        do_mm2s(12'h010, 8, 4'h2, 1);

        // ---- address wrap at the BRAM boundary
        do_s2mm(12'hFFE, 4, 4'h3, 3, 1'b0, 64'hA5A5_0000_0000_0000);
        check("wrap_mem_ffe", bram_mem[12'hFFE], 64'hA5A5_0000_0000_0000);
        check("wrap_mem_001", bram_mem[12'h001], 64'hA5A5_0000_0000_0003);
        do_mm2s(12'hFFE, 4, 4'h4, 0);

        // ---- early and missing tlast
        do_s2mm(12'h200, 8, 4'h6, 3, 1'b0, 64'h1000);
        do_s2mm(12'h300, 4, 4'h7, -1, 1'b0, 64'h2000);

        // ---- zero-length command
        @(posedge clk_in1); #1;
        cmd_valid = 1'b1; cmd_write = DIR_S2MM; cmd_addr = 12'h123; cmd_len = '0; cmd_tag = 4'h5;
        @(negedge clk_in1);
        check("zero_cmd_ready", cmd_ready, 1);
        check("zero_no_bram_en_accept", bram_en, 0);
        @(posedge clk_in1); #1;
        cmd_valid = 1'b0;
        @(negedge clk_in1);
        check("zero_no_bram_en", bram_en, 0);
        check("zero_no_tready", s_axis_tready, 0);
        check("zero_sts_valid", sts_valid, 1);
        check("zero_sts_tag",   sts_tag, 5);
        check("zero_sts_beats", sts_beats, 0);
        check("zero_sts_err",   sts_err, 3'b001);
        @(posedge clk_in1); #1;
        @(negedge clk_in1);
        check("zero_sts_one_cycle", sts_valid, 0);
        check("zero_cmd_ready_back", cmd_ready, 1);

        // ---- reset in the middle of a 16-beat MM2S
        do_s2mm(12'h400, 16, 4'h8, 15, 1'b1, {$urandom, $urandom});
        drive_cmd(DIR_MM2S, 12'h400, 16, 4'h9);
        m_axis_tready = 1'b1;
        k = 0; c = 0;
        while (k < 3 && c < 100) begin
            @(negedge clk_in1);
            if (m_axis_tvalid && m_axis_tready) begin
                check("rstmid_tdata", m_axis_tdata, ref_mem[12'h400 + k]);
                k++;
            end
            @(posedge clk_in1); #1;
            c++;
        end
        if (k < 3) check("rstmid_timeout_beats", k, 3);
        reset = 1'b1;
        @(posedge clk_in1);
        @(negedge clk_in1);
        check("rstmid_cmd_ready",  cmd_ready, 0);
        check("rstmid_s_tready",   s_axis_tready, 0);
        check("rstmid_m_tvalid",   m_axis_tvalid, 0);
        check("rstmid_m_tlast",    m_axis_tlast, 0);
        check("rstmid_m_tdata",    m_axis_tdata, 0);
        check("rstmid_bram_en",    bram_en, 0);
        check("rstmid_bram_we",    bram_we, 0);
        check("rstmid_bram_addr",  bram_addr, 0);
        check("rstmid_bram_wdata", bram_wdata, 0);
        check("rstmid_sts_valid",  sts_valid, 0);
        check("rstmid_sts_fields", {sts_tag, sts_beats, sts_err}, 0);
        @(posedge clk_in1); #1;
        reset = 1'b0;
        @(negedge clk_in1);
        check("rstmid_release_no_sts", sts_valid, 0);
        check("rstmid_release_m_tvalid", m_axis_tvalid, 0);
        @(posedge clk_in1); #1;
        @(negedge clk_in1);
        check("rstmid_cmd_ready_rises", cmd_ready, 1);
        check("rstmid_still_no_sts", sts_valid, 0);
        do_mm2s(12'h400, 16, 4'hA, 2);

        // ---- randomized round trips
        for (int n = 0; n < 6; n++) begin
            r_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            r_len  = $urandom_range(1, 24);
            do_s2mm(r_addr, r_len, 4'(n), r_len - 1, 1'b1, {$urandom, $urandom});
            do_mm2s(r_addr, r_len, 4'(n + 8), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_axis_bram_datamover
